// File: rtl/note_playback_if.sv
// Bundles the note_playback control, note-memory read port and audio/display outputs.
interface note_playback_if;
   logic        play_in;
   logic [1:0]  bpm_in;
   logic [4:0]  num_measures_in;
   logic [4:0]  addr_out;
   logic [47:0] data_in;
   logic [5:0]  note_out;
   logic        note_valid_out;
   logic [7:0]  slot_out;
   logic        tone_out;
   logic        playing_out;
   logic        done_out;

   // Player side: takes controls and memory data, drives address and audio.
   modport slave (
      input  play_in, bpm_in, num_measures_in, data_in,
      output addr_out, note_out, note_valid_out, slot_out, tone_out, playing_out, done_out
   );

   // Controller / memory side.
   modport master (
      output play_in, bpm_in, num_measures_in, data_in,
      input  addr_out, note_out, note_valid_out, slot_out, tone_out, playing_out, done_out
   );
endinterface

// File: rtl/note_playback.sv
// Plays stored measures from the note memory as a square-wave tone.
// Each 48-bit word is one measure of 8 six-bit eighth-note slots.
// Repeated identical notes sustain without restarting the tone phase.
// The next measure is prefetched while the current one plays, so there is no gap at the boundary.
module note_playback #(
   parameter int EIGHTH_60    = 37_125_000,
   parameter int EIGHTH_80    = 27_843_750,
   parameter int EIGHTH_120   = 18_562_500,
   parameter int MAX_MEASURES = 20,
   parameter int READ_LAT     = 2,
   parameter int TONE_SHIFT   = 0
) (
   input logic            clk_in,
   input logic            rst_in,
   note_playback_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

   // Tone half-periods in clk cycles, C4 (index 0) up to A5 (index 21).
   localparam logic [17:0] HALF_ROM [22] = '{
      18'd141902, 18'd133937, 18'd126420, 18'd119324, 18'd112627, 18'd106306,
      18'd100339, 18'd94708,  18'd89392,  18'd84375,  18'd79640,  18'd75170,
      18'd70951,  18'd66968,  18'd63210,  18'd59662,  18'd56314,  18'd53153,
      18'd50170,  18'd47354,  18'd44696,  18'd42188
   };

   localparam logic [4:0] MAX_M     = 5'(MAX_MEASURES);
   localparam logic [3:0] LAT_FETCH = 4'(READ_LAT);
   localparam logic [3:0] LAT_PREF  = 4'(READ_LAT + 1);
   localparam logic [3:0] LAT_SAT   = 4'(READ_LAT + 2);

   state_t      state_reg;
   logic        play_prev_reg;
   logic [4:0]  num_reg;
   logic [4:0]  measure_reg;
   logic [2:0]  slot_reg;
   logic [25:0] eighth_cnt_reg;
   logic [25:0] period_reg;
   logic [3:0]  lat_cnt_reg;
   logic [47:0] cur_buf_reg;
   logic [47:0] next_buf_reg;
   logic [17:0] phase_reg;
   logic        tone_reg;
   logic        note_active_reg;
   logic [5:0]  note_reg;
   logic        note_valid_reg;
   logic [7:0]  slot_out_reg;
   logic        playing_reg;
   logic        done_reg;
   logic [4:0]  addr_reg;

   logic [5:0]  cur_slot_code [8];
   logic [4:0]  num_clamped;
   logic        slot_end;
   logic        last_measure;
   logic        enter_slot;
   logic [5:0]  enter_code;
   logic [4:0]  enter_measure;
   logic [2:0]  enter_slot_idx;
   logic [17:0] half_cur;
   logic        phase_wrap;
   logic [17:0] phase_adv;
   logic        tone_adv;

   function automatic logic is_note(input logic [5:0] code);
      return code[5] && (code[4:0] <= 5'd21);
   endfunction

   function automatic logic [17:0] half_of(input logic [5:0] code);
      if (is_note(code)) return HALF_ROM[code[4:0]] >> TONE_SHIFT;
      return 18'd0;
   endfunction

   function automatic logic [25:0] period_of(input logic [1:0] bpm);
      case (bpm)
         2'b01:   return 26'(EIGHTH_80);
         2'b10:   return 26'(EIGHTH_120);
         default: return 26'(EIGHTH_60);
      endcase
   endfunction

   for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      assign cur_slot_code[gi] = cur_buf_reg[6*gi +: 6];
   end

   assign num_clamped  = (bus.num_measures_in > MAX_M) ? MAX_M : bus.num_measures_in;
   assign slot_end     = (eighth_cnt_reg == period_reg - 26'd1);
   assign last_measure = (measure_reg == num_reg - 5'd1);
   assign half_cur     = half_of(note_reg);
   assign phase_wrap   = (phase_reg == half_cur - 18'd1);
   assign phase_adv    = phase_wrap ? 18'd0 : phase_reg + 18'd1;
   assign tone_adv     = phase_wrap ? ~tone_reg : tone_reg;

   // Decide whether a new slot begins on this edge, and which code/position it carries.
   always_comb begin
      enter_slot     = 1'b0;
      enter_code     = 6'd0;
      enter_measure  = measure_reg;
      enter_slot_idx = slot_reg + 3'd1;
      if (state_reg == FETCH && bus.play_in && lat_cnt_reg == LAT_FETCH) begin
         enter_slot     = 1'b1;
         enter_code     = bus.data_in[5:0];
         enter_measure  = 5'd0;
         enter_slot_idx = 3'd0;
      end else if (state_reg == PLAY && bus.play_in && slot_end &&
                   !(slot_reg == 3'd7 && last_measure)) begin
         enter_slot = 1'b1;
         if (slot_reg == 3'd7) begin
            enter_code    = next_buf_reg[5:0];
            enter_measure = measure_reg + 5'd1;
         end else begin
            enter_code = cur_slot_code[enter_slot_idx];
         end
      end
   end

   // Playback FSM, slot timing, measure prefetch and tone generation.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg       <= IDLE;
         play_prev_reg   <= 1'b0;
         num_reg         <= '0;
         measure_reg     <= '0;
         slot_reg        <= '0;
         eighth_cnt_reg  <= '0;
         period_reg      <= '0;
         lat_cnt_reg     <= '0;
         cur_buf_reg     <= '0;
         next_buf_reg    <= '0;
         phase_reg       <= '0;
         tone_reg        <= 1'b0;
         note_active_reg <= 1'b0;
         note_reg        <= '0;
         note_valid_reg  <= 1'b0;
         slot_out_reg    <= '0;
         playing_reg     <= 1'b0;
         done_reg        <= 1'b0;
         addr_reg        <= '0;
      end else begin
         play_prev_reg  <= bus.play_in;
         note_valid_reg <= 1'b0;
         done_reg       <= 1'b0;

         // Slot start: publish the note, load the tempo, retrigger or sustain the tone.
         if (enter_slot) begin
            slot_reg       <= enter_slot_idx;
            measure_reg    <= enter_measure;
            slot_out_reg   <= {enter_measure, enter_slot_idx};
            note_reg       <= enter_code;
            note_valid_reg <= 1'b1;
            period_reg     <= period_of(bus.bpm_in);
            eighth_cnt_reg <= '0;
            if (!is_note(enter_code)) begin
               tone_reg        <= 1'b0;
               phase_reg       <= '0;
               note_active_reg <= 1'b0;
            end else if (note_active_reg && enter_code == note_reg) begin
               phase_reg <= phase_adv;
               tone_reg  <= tone_adv;
            end else begin
               tone_reg        <= 1'b1;
               phase_reg       <= '0;
               note_active_reg <= 1'b1;
            end
         end else if (state_reg == PLAY) begin
            eighth_cnt_reg <= eighth_cnt_reg + 26'd1;
            if (note_active_reg) begin
               phase_reg <= phase_adv;
               tone_reg  <= tone_adv;
            end
         end

         case (state_reg)
            IDLE: begin
               if (bus.play_in && !play_prev_reg) begin
                  if (num_clamped == 5'd0) begin
                     done_reg <= 1'b1;
                  end else begin
                     state_reg   <= FETCH;
                     playing_reg <= 1'b1;
                     num_reg     <= num_clamped;
                     measure_reg <= '0;
                     addr_reg    <= '0;
                     lat_cnt_reg <= '0;
                  end
               end
            end
            FETCH: begin
               if (!bus.play_in) begin
                  state_reg       <= IDLE;
                  playing_reg     <= 1'b0;
                  tone_reg        <= 1'b0;
                  phase_reg       <= '0;
                  note_reg        <= '0;
                  note_active_reg <= 1'b0;
                  addr_reg        <= '0;
               end else if (lat_cnt_reg == LAT_FETCH) begin
                  cur_buf_reg <= bus.data_in;
                  state_reg   <= PLAY;
                  lat_cnt_reg <= '0;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg + 4'd1;
               end
            end
            PLAY: begin
               if (!bus.play_in) begin
                  state_reg       <= IDLE;
                  playing_reg     <= 1'b0;
                  tone_reg        <= 1'b0;
                  phase_reg       <= '0;
                  note_reg        <= '0;
                  note_active_reg <= 1'b0;
                  addr_reg        <= '0;
               end else begin
                  // Prefetch: address goes out one cycle into the measure, data lands READ_LAT later.
                  if (lat_cnt_reg == 4'd0) begin
                     if (measure_reg + 5'd1 < num_reg) addr_reg <= measure_reg + 5'd1;
                     lat_cnt_reg <= 4'd1;
                  end else if (lat_cnt_reg == LAT_PREF) begin
                     next_buf_reg <= bus.data_in;
                     lat_cnt_reg  <= LAT_SAT;
                  end else if (lat_cnt_reg < LAT_SAT) begin
                     lat_cnt_reg <= lat_cnt_reg + 4'd1;
                  end
                  if (slot_end && slot_reg == 3'd7) begin
                     if (last_measure) begin
                        done_reg        <= 1'b1;
                        state_reg       <= IDLE;
                        playing_reg     <= 1'b0;
                        tone_reg        <= 1'b0;
                        phase_reg       <= '0;
                        note_reg        <= '0;
                        note_active_reg <= 1'b0;
                     end else begin
                        cur_buf_reg <= next_buf_reg;
                        lat_cnt_reg <= '0;
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.addr_out       = addr_reg;
   assign bus.note_out       = note_reg;
   assign bus.note_valid_out = note_valid_reg;
   assign bus.slot_out       = slot_out_reg;
   assign bus.tone_out       = tone_reg;
   assign bus.playing_out    = playing_reg;
   assign bus.done_out       = done_reg;

endmodule
